// File: rtl/mips_pkg.sv
// Shared encodings, sizes and control bundle for the single-cycle
// MIPS subset core.
package mips_pkg;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam int          IM_WORDS = 1024;
   localparam int          DM_BYTES = 4096;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_JR   = 6'h08;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_OR,
      ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {
      NPC_SEQ,
      NPC_BEQ,
      NPC_JMP,
      NPC_JR
   } npc_op_e;

   typedef enum logic [1:0] {
      DST_RT,
      DST_RD,
      DST_RA
   } reg_dst_e;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_PC4
   } wb_sel_e;

   typedef struct packed {
      reg_dst_e reg_dst;
      logic     alu_src;
      logic     ext_op;
      logic     mem_wr;
      logic     reg_wr;
      wb_sel_e  mem_to_reg;
      npc_op_e  npc_op;
      alu_op_e  alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      reg_dst:    DST_RT,
      alu_src:    1'b0,
      ext_op:     1'b0,
      mem_wr:     1'b0,
      reg_wr:     1'b0,
      mem_to_reg: WB_ALU,
      npc_op:     NPC_SEQ,
      alu_op:     ALU_ADD
   };

endpackage

// File: rtl/mips_cpu_ctrl.sv
// Main decoder: opcode/funct to datapath controls. Anything not
// recognised decodes to a NOP.
module ctrl
   import mips_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = CTRL_NOP;
      unique case (op_i)
         OP_R: begin
            unique case (funct_i)
               FN_ADDU: begin
                  ctrl_o.reg_dst = DST_RD;
                  ctrl_o.reg_wr  = 1'b1;
                  ctrl_o.alu_op  = ALU_ADD;
               end
               FN_SUBU: begin
                  ctrl_o.reg_dst = DST_RD;
                  ctrl_o.reg_wr  = 1'b1;
                  ctrl_o.alu_op  = ALU_SUB;
               end
               FN_JR: begin
                  ctrl_o.npc_op = NPC_JR;
               end
               default: ;
            endcase
         end
         OP_ORI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.reg_wr  = 1'b1;
            ctrl_o.alu_op  = ALU_OR;
         end
         OP_LUI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.reg_wr  = 1'b1;
            ctrl_o.alu_op  = ALU_LUI;
         end
         OP_LW: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.ext_op     = 1'b1;
            ctrl_o.reg_wr     = 1'b1;
            ctrl_o.mem_to_reg = WB_MEM;
         end
         OP_SW: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.ext_op  = 1'b1;
            ctrl_o.mem_wr  = 1'b1;
         end
         OP_BEQ: begin
            ctrl_o.ext_op = 1'b1;
            ctrl_o.npc_op = NPC_BEQ;
         end
         OP_J: begin
            ctrl_o.npc_op = NPC_JMP;
         end
         OP_JAL: begin
            ctrl_o.npc_op     = NPC_JMP;
            ctrl_o.reg_wr     = 1'b1;
            ctrl_o.reg_dst    = DST_RA;
            ctrl_o.mem_to_reg = WB_PC4;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_cpu_gpr.sv
// 32x32 register file: two async read ports, one clocked write port,
// $0 hardwired to zero.
module gpr (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   input  logic [4:0]  wa_i,
   input  logic        we_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o
);

   logic [31:0] regs [31:0] = '{default: '0};

   assign rd1_o = (ra1_i == 5'd0) ? '0 : regs[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? '0 : regs[ra2_i];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         regs[wa_i] <= wd_i;
      end
   end

endmodule

// File: rtl/mips_cpu_mem.sv
// Instruction ROM (word-addressed) and little-endian byte data RAM
// with combinational reads and clocked writes.
module im_4k
   import mips_pkg::*;
(
   input  logic [9:0]  addr_i,
   output logic [31:0] instr_o
);

   logic [31:0] im [0:IM_WORDS-1] = '{default: '0};

   assign instr_o = im[addr_i];

endmodule

module dm_4k
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [9:0]  waddr_i,
   input  logic        we_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd_o
);

   logic [7:0] dm [0:DM_BYTES-1] = '{default: '0};

   logic [11:0] a0, a1, a2, a3;

   assign a0 = {waddr_i, 2'd0};
   assign a1 = {waddr_i, 2'd1};
   assign a2 = {waddr_i, 2'd2};
   assign a3 = {waddr_i, 2'd3};

   assign rd_o = {dm[a3], dm[a2], dm[a1], dm[a0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DM_BYTES; i++) begin
            dm[i] <= '0;
         end
      end else if (we_i) begin
         dm[a0] <= wd_i[7:0];
         dm[a1] <= wd_i[15:8];
         dm[a2] <= wd_i[23:16];
         dm[a3] <= wd_i[31:24];
      end
   end

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core: each rising edge retires one
// instruction (fetch, decode, ALU, memory, writeback, next PC).
module mips_cpu
   import mips_pkg::*;
(
   input logic clk,
   input logic rst
);

   logic [31:0] pc_q = PC_RESET;
   logic [31:0] pc_d;

   logic [31:0] instr, pc4, ext, rd1, rd2;
   logic [31:0] alu_b, alu_y, dm_rd, wd;
   logic [31:0] br_tgt, j_tgt;
   logic [9:0]  im_idx;
   logic [4:0]  rs, rt, rd, wa;
   ctrl_t       c;

   // Offset from the image base; high bits drop so fetches alias in 4 KB.
   assign im_idx = pc_q[11:2] - PC_RESET[11:2];

   im_4k im1 (
      .addr_i  (im_idx),
      .instr_o (instr)
   );

   assign rs = instr[25:21];
   assign rt = instr[20:16];
   assign rd = instr[15:11];

   ctrl u_ctrl (
      .op_i    (instr[31:26]),
      .funct_i (instr[5:0]),
      .ctrl_o  (c)
   );

   gpr g1 (
      .clk_i (clk),
      .rst_i (rst),
      .ra1_i (rs),
      .ra2_i (rt),
      .wa_i  (wa),
      .we_i  (c.reg_wr),
      .wd_i  (wd),
      .rd1_o (rd1),
      .rd2_o (rd2)
   );

   assign ext = c.ext_op ? {{16{instr[15]}}, instr[15:0]}
                         : {16'h0, instr[15:0]};

   assign alu_b = c.alu_src ? ext : rd2;

   always_comb begin
      unique case (c.alu_op)
         ALU_SUB: alu_y = rd1 - alu_b;
         ALU_OR:  alu_y = rd1 | alu_b;
         ALU_LUI: alu_y = {alu_b[15:0], 16'h0};
         default: alu_y = rd1 + alu_b;
      endcase
   end

   dm_4k d1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .waddr_i (alu_y[11:2]),
      .we_i    (c.mem_wr),
      .wd_i    (rd2),
      .rd_o    (dm_rd)
   );

   always_comb begin
      unique case (c.reg_dst)
         DST_RD:  wa = rd;
         DST_RA:  wa = 5'd31;
         default: wa = rt;
      endcase
   end

   always_comb begin
      unique case (c.mem_to_reg)
         WB_MEM:  wd = dm_rd;
         WB_PC4:  wd = pc4;
         default: wd = alu_y;
      endcase
   end

   assign pc4    = pc_q + 32'd4;
   assign br_tgt = pc4 + {ext[29:0], 2'b00};
   assign j_tgt  = {pc4[31:28], instr[25:0], 2'b00};

   always_comb begin
      pc_d = pc4;
      unique case (c.npc_op)
         NPC_BEQ: if (rd1 == rd2) pc_d = br_tgt;
         NPC_JMP: pc_d = j_tgt;
         NPC_JR:  pc_d = rd1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu.sv
// Scoreboard bench for mips_cpu: each scenario loads a program,
// queues expected architectural state, runs, then compares.
module tb_mips_cpu;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   localparam int K_REG = 0;
   localparam int K_DMW = 1;
   localparam int K_PC  = 2;
   localparam int K_DMB = 3;

   localparam logic [5:0] ORI  = 6'h0D;
   localparam logic [5:0] LUI  = 6'h0F;
   localparam logic [5:0] LW   = 6'h23;
   localparam logic [5:0] SW   = 6'h2B;
   localparam logic [5:0] BEQ  = 6'h04;
   localparam logic [5:0] J    = 6'h02;
   localparam logic [5:0] JAL  = 6'h03;
   localparam logic [5:0] ADDU = 6'h21;
   localparam logic [5:0] SUBU = 6'h23;
   localparam logic [5:0] JR   = 6'h08;

   typedef struct {
      string       name;
      int          kind;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   mips_cpu dut (
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ri(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] rd,
                                      input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] ii(input logic [5:0] op,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jj(input logic [5:0] op,
                                      input logic [25:0] t);
      return {op, t};
   endfunction

   function automatic logic [31:0] observe(input int kind, input int idx);
      logic [11:0] a;
      logic [4:0]  r;
      a = idx[11:0];
      r = idx[4:0];
      if (kind == K_REG) return dut.g1.regs[r];
      if (kind == K_PC) return dut.pc_q;
      if (kind == K_DMB) return {24'h0, dut.d1.dm[a]};
      return {dut.d1.dm[a + 12'd3], dut.d1.dm[a + 12'd2],
              dut.d1.dm[a + 12'd1], dut.d1.dm[a]};
   endfunction

   task automatic start(input logic [31:0] p[$]);
      logic [9:0] w;
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         w = i[9:0];
         dut.im1.im[w] = (i < p.size()) ? p[i] : 32'h0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] obs;
      sb.push_back('{"poweron_pc", K_PC, 0, 32'h0000_3000});
      sb.push_back('{"poweron_r31", K_REG, 31, 32'h0});
      sb.push_back('{"poweron_dm0", K_DMW, 0, 32'h0});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{"reset_pc", K_PC, 0, 32'h0000_3000});
      for (int r = 0; r < 32; r++) begin
         sb.push_back('{$sformatf("reset_r%0d", r), K_REG, r, 32'h0});
      end
      sb.push_back('{"reset_dm0", K_DMW, 0, 32'h0});
      sb.push_back('{"reset_dm4092", K_DMW, 4092, 32'h0});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_alu();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h1234),
           ii(LUI, 5'd0, 5'd2, 16'hABCD),
           ri(5'd1, 5'd2, 5'd3, ADDU),
           ii(ORI, 5'd0, 5'd5, 16'h0001),
           ri(5'd0, 5'd5, 5'd6, SUBU),
           ii(ORI, 5'd0, 5'd0, 16'hFFFF),
           ii(ORI, 5'd0, 5'd7, 16'h0005),
           ri(5'd7, 5'd7, 5'd7, ADDU),
           ri(5'd7, 5'd6, 5'd8, SUBU),
           ri(5'd6, 5'd6, 5'd9, ADDU),
           ii(ORI, 5'd0, 5'd10, 16'h8000)};
      start(p);
      sb.push_back('{"alu_r1", K_REG, 1, 32'h0000_1234});
      sb.push_back('{"alu_r2", K_REG, 2, 32'hABCD_0000});
      sb.push_back('{"alu_r3", K_REG, 3, 32'hABCD_1234});
      sb.push_back('{"alu_r5", K_REG, 5, 32'h0000_0001});
      sb.push_back('{"alu_r6_wrap", K_REG, 6, 32'hFFFF_FFFF});
      sb.push_back('{"alu_r0", K_REG, 0, 32'h0});
      sb.push_back('{"alu_r7_self", K_REG, 7, 32'h0000_000A});
      sb.push_back('{"alu_r8", K_REG, 8, 32'h0000_000B});
      sb.push_back('{"alu_r9", K_REG, 9, 32'hFFFF_FFFE});
      sb.push_back('{"alu_r10_zext", K_REG, 10, 32'h0000_8000});
      sb.push_back('{"alu_pc", K_PC, 0, 32'h0000_302C});
      repeat (11) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_mem();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h1234),
           ii(LUI, 5'd0, 5'd2, 16'hABCD),
           ri(5'd1, 5'd2, 5'd3, ADDU),
           ii(SW, 5'd0, 5'd3, 16'h0004),
           ii(LW, 5'd0, 5'd4, 16'h0004),
           ii(SW, 5'd0, 5'd1, 16'h0009),
           ii(LW, 5'd0, 5'd8, 16'h000B),
           ii(ORI, 5'd0, 5'd9, 16'h0020),
           ii(SW, 5'd9, 5'd3, 16'hFFFC),
           ii(LW, 5'd0, 5'd10, 16'h001C),
           ii(LW, 5'd0, 5'd11, 16'h1004),
           ii(SW, 5'd0, 5'd9, 16'h0FFC)};
      start(p);
      sb.push_back('{"mem_b4", K_DMB, 4, 32'h34});
      sb.push_back('{"mem_b5", K_DMB, 5, 32'h12});
      sb.push_back('{"mem_b6", K_DMB, 6, 32'hCD});
      sb.push_back('{"mem_b7", K_DMB, 7, 32'hAB});
      sb.push_back('{"mem_lw_r4", K_REG, 4, 32'hABCD_1234});
      sb.push_back('{"mem_align_w8", K_DMW, 8, 32'h0000_1234});
      sb.push_back('{"mem_align_r8", K_REG, 8, 32'h0000_1234});
      sb.push_back('{"mem_neg_w1c", K_DMW, 28, 32'hABCD_1234});
      sb.push_back('{"mem_lw_r10", K_REG, 10, 32'hABCD_1234});
      sb.push_back('{"mem_alias_r11", K_REG, 11, 32'hABCD_1234});
      sb.push_back('{"mem_top_w", K_DMW, 4092, 32'h0000_0020});
      sb.push_back('{"mem_pc", K_PC, 0, 32'h0000_3030});
      repeat (12) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_branch();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h0001),
           ii(ORI, 5'd0, 5'd2, 16'h0002),
           ii(BEQ, 5'd1, 5'd1, 16'h0001),
           ii(ORI, 5'd0, 5'd3, 16'h0BAD),
           ii(BEQ, 5'd1, 5'd2, 16'h0001),
           ii(ORI, 5'd0, 5'd4, 16'h0044),
           jj(JAL, 26'h0000C09),
           ii(ORI, 5'd0, 5'd5, 16'h0055),
           jj(J, 26'h0000C0B),
           ii(ORI, 5'd0, 5'd6, 16'h0066),
           ri(5'd31, 5'd0, 5'd0, JR),
           ii(ORI, 5'd0, 5'd7, 16'h0077),
           ii(BEQ, 5'd0, 5'd0, 16'hFFFF)};
      start(p);
      sb.push_back('{"br_taken_skip", K_REG, 3, 32'h0});
      sb.push_back('{"br_fallthru", K_REG, 4, 32'h0000_0044});
      sb.push_back('{"jal_ra", K_REG, 31, 32'h0000_301C});
      sb.push_back('{"jal_body", K_REG, 6, 32'h0000_0066});
      sb.push_back('{"jr_return", K_REG, 5, 32'h0000_0055});
      sb.push_back('{"j_target", K_REG, 7, 32'h0000_0077});
      sb.push_back('{"br_back_pc", K_PC, 0, 32'h0000_3030});
      repeat (14) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_jump();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h0007),
           jj(J, 26'h0000C00)};
      start(p);
      sb.push_back('{"jloop_r1", K_REG, 1, 32'h0000_0007});
      sb.push_back('{"jloop_pc3", K_PC, 0, 32'h0000_3004});
      repeat (3) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
      sb.push_back('{"jloop_pc4", K_PC, 0, 32'h0000_3000});
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_alias();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h4008),
           ri(5'd1, 5'd0, 5'd0, JR),
           ii(ORI, 5'd0, 5'd3, 16'h0033)};
      start(p);
      sb.push_back('{"alias_r3", K_REG, 3, 32'h0000_0033});
      sb.push_back('{"alias_pc", K_PC, 0, 32'h0000_400C});
      repeat (3) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_nop();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h1234),
           ii(SW, 5'd0, 5'd1, 16'h0000),
           32'hFC21_FFFF,
           ri(5'd1, 5'd1, 5'd2, 6'h20)};
      start(p);
      sb.push_back('{"nop_r1", K_REG, 1, 32'h0000_1234});
      sb.push_back('{"nop_r2", K_REG, 2, 32'h0});
      sb.push_back('{"nop_dm0", K_DMW, 0, 32'h0000_1234});
      sb.push_back('{"nop_pc", K_PC, 0, 32'h0000_3010});
      repeat (4) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [31:0] obs;
      logic [31:0] p[$];
      p = {ii(ORI, 5'd0, 5'd1, 16'h1234),
           ii(LUI, 5'd0, 5'd2, 16'hABCD),
           ri(5'd1, 5'd2, 5'd3, ADDU),
           ii(SW, 5'd0, 5'd3, 16'h0004),
           ii(ORI, 5'd0, 5'd9, 16'h0099)};
      start(p);
      sb.push_back('{"mid_pre_dm4", K_DMW, 4, 32'hABCD_1234});
      sb.push_back('{"mid_pre_pc", K_PC, 0, 32'h0000_3010});
      repeat (4) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
      rst = 1'b1;
      sb.push_back('{"mid_pc", K_PC, 0, 32'h0000_3000});
      sb.push_back('{"mid_r1", K_REG, 1, 32'h0});
      sb.push_back('{"mid_r3", K_REG, 3, 32'h0});
      sb.push_back('{"mid_r9", K_REG, 9, 32'h0});
      sb.push_back('{"mid_dm4", K_DMW, 4, 32'h0});
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind, e.idx);
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", e.name, obs, e.exp);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_jump();
      test_alias();
      test_nop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
